counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 139 +++++++++++++
 tb/tb_counter_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting four requesters exclusive access to one shared counter.
// Define COUNTER_ARBITER_SATURATE_EN to clamp inc/dec at the range limits instead of wrapping.
module counter_arbiter #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [7:0]         op,
   input  logic [4*WIDTH-1:0] load_value,
   output logic [3:0]         grant,
   output logic               done,
   output logic               busy,
   output logic [WIDTH-1:0]   counter
);

   typedef enum logic [1:0] {IDLE, GRANT, APPLY, RELEASE} state_t;

   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

   state_t           state_reg, state_next;
   logic [1:0]       ptr_reg, ptr_next;
   logic [1:0]       winner_reg, winner_next;
   logic [3:0]       grant_reg, grant_next;
   logic [1:0]       op_reg, op_next;
   logic [WIDTH-1:0] operand_reg, operand_next;
   logic [WIDTH-1:0] counter_reg, counter_next;
   logic             done_reg, done_next;

   logic [1:0]       scan_idx [4];
   logic [1:0]       pick;
   logic             pick_valid;
   logic [WIDTH:0]   sum_ext, diff_ext;
   logic [WIDTH-1:0] inc_value, dec_value;

   // Candidate order starting at the pointer; 2-bit addition gives the mod-4 wrap.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_scan
         assign scan_idx[gi] = ptr_reg + 2'(gi);
      end
   endgenerate

   always_comb begin
      pick       = 2'd0;
      pick_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!pick_valid && req[scan_idx[k]]) begin
            pick       = scan_idx[k];
            pick_valid = 1'b1;
         end
      end
   end

   // The extra top bit carries overflow on inc and borrow on dec.
   assign sum_ext  = {1'b0, counter_reg} + STEP_EXT;
   assign diff_ext = {1'b0, counter_reg} - STEP_EXT;

`ifdef COUNTER_ARBITER_SATURATE_EN
   assign inc_value = sum_ext[WIDTH]  ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
   assign dec_value = diff_ext[WIDTH] ? {WIDTH{1'b0}} : diff_ext[WIDTH-1:0];
`else
   assign inc_value = sum_ext[WIDTH-1:0];
   assign dec_value = diff_ext[WIDTH-1:0];
`endif

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      winner_next  = winner_reg;
      grant_next   = grant_reg;
      op_next      = op_reg;
      operand_next = operand_reg;
      counter_next = counter_reg;
      done_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               winner_next = pick;
               grant_next  = 4'b0001 << pick;
               state_next  = GRANT;
            end
         end
         GRANT: begin
            // Operands are captured here so a dropped req cannot disturb the operation.
            op_next      = op[{winner_reg, 1'b0} +: 2];
            operand_next = load_value[int'(winner_reg)*WIDTH +: WIDTH];
            state_next   = APPLY;
         end
         APPLY: begin
            case (op_reg)
               2'b00:   counter_next = inc_value;
               2'b01:   counter_next = dec_value;
               2'b10:   counter_next = operand_reg;
               default: counter_next = counter_reg;
            endcase
            done_next  = 1'b1;
            ptr_next   = winner_reg + 2'd1;
            state_next = RELEASE;
         end
         RELEASE: begin
            if (!req[winner_reg]) begin
               grant_next = 4'b0000;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         ptr_reg     <= 2'd0;
         winner_reg  <= 2'd0;
         grant_reg   <= 4'b0000;
         op_reg      <= 2'b11;
         operand_reg <= '0;
         counter_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         winner_reg  <= winner_next;
         grant_reg   <= grant_next;
         op_reg      <= op_next;
         operand_reg <= operand_next;
         counter_reg <= counter_next;
         done_reg    <= done_next;
      end
   end

   assign grant   = grant_reg;
   assign done    = done_reg;
   assign busy    = (state_reg != IDLE);
   assign counter = counter_reg;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter; expected counter values are queued when a request
// is posted and popped when done pulses.
module tb_counter_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [63:0] load_value;
   logic [3:0]  grant;
   logic        done;
   logic        busy;
   logic [15:0] counter;

   int          passed = 0;
   int          total  = 0;
   logic [15:0] model_cnt = 16'd0;
   logic [15:0] exp_q [$];

`ifdef COUNTER_ARBITER_SATURATE_EN
   localparam logic [15:0] EXP_INC_TOP = 16'hFFFF;
   localparam logic [15:0] EXP_DEC_BOT = 16'h0000;
`else
   localparam logic [15:0] EXP_INC_TOP = 16'h0000;
   localparam logic [15:0] EXP_DEC_BOT = 16'hFFFF;
`endif

   counter_arbiter #(.WIDTH(16), .STEP(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .op         (op),
      .load_value (load_value),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .counter    (counter)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model(input logic [15:0] c, input logic [1:0] o,
                                         input logic [15:0] v);
      case (o)
`ifdef COUNTER_ARBITER_SATURATE_EN
         2'b00:   model = (c == 16'hFFFF) ? c : c + 16'd1;
         2'b01:   model = (c == 16'h0000) ? c : c - 16'd1;
`else
         2'b00:   model = c + 16'd1;
         2'b01:   model = c - 16'd1;
`endif
         2'b10:   model = v;
         default: model = c;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $display("check %-12s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req = 4'b0000;
      op = 8'h00;
      load_value = 64'h0;
      tick;
      tick;
      reset = 1'b0;
      model_cnt = 16'd0;
      exp_q.delete();
   endtask

   task automatic post(input int idx, input logic [1:0] opc, input logic [15:0] val);
      op[2*idx +: 2] = opc;
      load_value[16*idx +: 16] = val;
      req[idx] = 1'b1;
      model_cnt = model(model_cnt, opc, val);
      exp_q.push_back(model_cnt);
   endtask

   task automatic wait_grant(input string tag, input logic [3:0] exp);
      int n = 0;
      while (grant === 4'b0000 && n < 12) begin
         tick;
         n++;
      end
      check({tag, "_g"}, 64'(grant), 64'(exp));
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 12) begin
         tick;
         n++;
      end
      check({tag, "_d"}, 64'(done), 64'd1);
      if (done === 1'b1) begin
         if (exp_q.size() > 0) check({tag, "_c"}, 64'(counter), 64'(exp_q.pop_front()));
         else check({tag, "_q"}, 64'(exp_q.size()), 64'd1);
      end
   endtask

   task automatic serve(input string tag, input logic [3:0] exp_grant);
      wait_grant(tag, exp_grant);
      wait_done(tag);
      req = req & ~exp_grant;
      tick;
      check({tag, "_r"}, 64'(grant), 64'd0);
      check({tag, "_p"}, 64'(done), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      op = 8'h00;
      load_value = 64'h0;
      tick;
      tick;
      check("rst_cnt", 64'(counter), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;

      // single increment with cycle-exact latency
      post(0, 2'b00, 16'h0);
      tick;
      check("lat_g", 64'(grant), 64'h1);
      check("lat_busy", 64'(busy), 64'd1);
      check("lat_d0", 64'(done), 64'd0);
      tick;
      check("lat_d1", 64'(done), 64'd0);
      check("lat_c1", 64'(counter), 64'd0);
      tick;
      check("lat_d2", 64'(done), 64'd1);
      check("lat_c2", 64'(counter), 64'(exp_q.pop_front()));
      req = 4'b0000;
      tick;
      check("lat_rel", 64'(grant), 64'd0);
      check("lat_idle", 64'(busy), 64'd0);
      check("lat_pulse", 64'(done), 64'd0);

      // round robin with all four requesting
      do_reset;
      for (int i = 0; i < 4; i++) post(i, 2'b00, 16'h0);
      for (int i = 0; i < 4; i++) serve($sformatf("rr%0d", i), 4'(1 << i));
      check("rr_final", 64'(counter), 64'd4);

      // load top value then increment
      do_reset;
      post(2, 2'b10, 16'hFFFF);
      serve("ld", 4'b0100);
      post(2, 2'b00, 16'h0);
      serve("ld_inc", 4'b0100);
      check("inc_top", 64'(counter), 64'(EXP_INC_TOP));

      // decrement at zero, then hold
      do_reset;
      post(1, 2'b01, 16'h0);
      serve("dec", 4'b0010);
      check("dec_bot", 64'(counter), 64'(EXP_DEC_BOT));
      post(1, 2'b11, 16'h1234);
      serve("hold", 4'b0010);
      check("hold_val", 64'(counter), 64'(EXP_DEC_BOT));

      // reset while in APPLY abandons the operation
      do_reset;
      post(0, 2'b10, 16'd5);
      serve("ld5", 4'b0001);
      check("ld5_val", 64'(counter), 64'd5);
      op[7:6] = 2'b00;
      req[3] = 1'b1;
      tick;
      check("ab_g", 64'(grant), 64'h8);
      tick;
      check("ab_d", 64'(done), 64'd0);
      reset = 1'b1;
      #1;
      check("ab_cnt", 64'(counter), 64'd0);
      check("ab_grant", 64'(grant), 64'd0);
      check("ab_busy", 64'(busy), 64'd0);
      req = 4'b0000;
      tick;
      check("ab_nodone", 64'(done), 64'd0);
      tick;
      check("ab_cnt2", 64'(counter), 64'd0);
      reset = 1'b0;
      model_cnt = 16'd0;
      post(0, 2'b00, 16'h0);
      post(3, 2'b00, 16'h0);
      serve("ptr0", 4'b0001);
      serve("ptr3", 4'b1000);
      post(2, 2'b00, 16'h0);
      serve("ptr2", 4'b0100);

      // winner holds req while another is pending
      do_reset;
      post(0, 2'b00, 16'h0);
      wait_grant("hold", 4'b0001);
      wait_done("hold");
      post(1, 2'b00, 16'h0);
      for (int k = 0; k < 3; k++) begin
         tick;
         check($sformatf("keep%0d", k), 64'(grant), 64'h1);
      end
      req[0] = 1'b0;
      tick;
      check("keep_rel", 64'(grant), 64'd0);
      serve("pend", 4'b0010);

      check("q_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
